sequencer_beat_gen: RTL and testbench
=====================================

Name: sequencer_beat_gen

Overview:
Tempo-driven step clock that sits directly upstream of the sequencer player.
- Generates the 3-bit beat index that the player consumes, plus a one-cycle strobe at each step advance.
- Tempo (BPM) is held in a register and adjusted with up/down buttons, clamped between limits.
- Step timing uses a phase accumulator, so any integer BPM needs no divider and shows no long-term drift.

Parameters:
- CLK_HZ, 10000, system clock frequency in Hz.
- BPM_DEFAULT, 120, tempo loaded at reset.
- BPM_MIN, 60, lower tempo clamp.
- BPM_MAX, 240, upper tempo clamp; must be ≤ 255.
- BPM_STEP, 10, tempo change per button press.
- NUM_BEATS, 8, steps per bar; beat wraps NUM_BEATS-1 → 0; must be ≤ 8.

Ports:
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  reset, asynchronous, active-low.
- sequencer_on  input  1  run enable, synchronous level.
- tempo_up  input  1  raw async button, active-high.
- tempo_down  input  1  raw async button, active-high.
- beat  output  3  current step index, 0..NUM_BEATS-1.
- beat_strobe  output  1  one-cycle pulse in the cycle beat takes a new value.
- bpm  output  8  current tempo register.

Behaviour:
- Reset (n_rst=0, asynchronous): beat=0, beat_strobe=0, bpm=BPM_DEFAULT, state=IDLE, acc=0, synchronizer and edge registers=0. Reset mid-run aborts immediately; after release the block resumes from IDLE.
- Constant THRESH = CLK_HZ*60.
- acc width = clog2(THRESH+BPM_MAX). Unsigned arithmetic throughout. Because bpm < THRESH, at most one wrap occurs per cycle.
- Button path: tempo_up and tempo_down each pass a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3).
- Tempo update on an edge event:
  - up only: bpm = min(bpm+BPM_STEP, BPM_MAX).
  - down only: bpm = max(bpm-BPM_STEP, BPM_MIN).
  - both in same cycle: no change.
  - bpm changes 3 cycles after the pin rises.
  - Holding a button gives exactly one step.
  - Tempo updates in both states.
  - A change does not clear acc; the new bpm applies from the next accumulate.
- FSM states IDLE, RUN:
  - IDLE: acc=0, beat=0, beat_strobe=0. If sequencer_on=1 → RUN, and beat_strobe=1 with beat=0 on the transition edge (step 0 announced).
  - RUN: each cycle sum=acc+bpm.
    - If sum ≥ THRESH: acc ← sum−THRESH; beat ← (beat==NUM_BEATS-1)?0:beat+1; beat_strobe ← 1.
    - Else: acc ← sum; beat_strobe ← 0.
  - RUN: if sequencer_on=0 → IDLE with acc=0, beat=0, beat_strobe=0. sequencer_on low overrides a wrap in that same cycle.
- Step period = THRESH/bpm cycles on average (5000 at 120 BPM, CLK_HZ=10000). For non-integer periods, spacing alternates floor/ceil with zero cumulative error.
- beat and beat_strobe are registered. The downstream player samples beat directly.

Test Plan:
1. CLK_HZ=100 (THRESH=6000), reset, sequencer_on=1 → strobe at RUN entry with beat=0; then strobes every 50 cycles, beat 1,2,…,7,0; exactly 8 strobes per 400 cycles.
2. Press tempo_up 13 times from 120 → bpm 130,…,240, stays 240 on further presses. Press tempo_down 20 times → clamps at 60. Holding up for 100 cycles → single +10.
3. tempo_up and tempo_down rising in the same cycle → bpm unchanged. Pin-to-bpm latency exactly 3 cycles.
4. Running at 120 BPM, drop sequencer_on for 1 cycle at beat=5 → beat=0, strobe=0 next cycle; re-raise → immediate strobe with beat=0, next strobe 50 cycles later.
5. bpm=70 with THRESH=6000 (period 85.714) → strobe gaps of 85/86 cycles; 7 steps take exactly 600 cycles.
6. Assert n_rst low asynchronously mid-cycle at beat=3, bpm=180 → outputs go to beat=0, strobe=0, bpm=120 without waiting for a clock edge; normal operation after release.

Source files
------------

// File: rtl/sequencer_beat_gen_if.sv
// Control/status bundle between the tempo panel/run switch and the step clock.
// The master drives the run enable and raw buttons; the slave returns beat, strobe and tempo.
interface sequencer_beat_gen_if;
  logic       sequencer_on;
  logic       tempo_up;
  logic       tempo_down;
  logic [2:0] beat;
  logic       beat_strobe;
  logic [7:0] bpm;

  modport master (
    output sequencer_on, tempo_up, tempo_down,
    input  beat, beat_strobe, bpm
  );

  modport slave (
    input  sequencer_on, tempo_up, tempo_down,
    output beat, beat_strobe, bpm
  );
endinterface

// File: rtl/sequencer_beat_gen.sv
// Tempo-driven step clock: a phase accumulator adds bpm every cycle and emits a step
// each time it crosses CLK_HZ*60, so any integer tempo divides without drift.
module sequencer_beat_gen #(
  parameter int CLK_HZ      = 10000,
  parameter int BPM_DEFAULT = 120,
  parameter int BPM_MIN     = 60,
  parameter int BPM_MAX     = 240,
  parameter int BPM_STEP    = 10,
  parameter int NUM_BEATS   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  sequencer_beat_gen_if.slave   bus
);

  localparam int THRESH = CLK_HZ * 60;
  localparam int ACC_W  = $clog2(THRESH + BPM_MAX);

  localparam logic [ACC_W-1:0] THRESH_W   = ACC_W'(THRESH);
  localparam logic [2:0]       LAST_BEAT  = 3'(NUM_BEATS - 1);
  localparam logic [8:0]       MAX_W      = 9'(BPM_MAX);
  localparam logic [8:0]       DN_FLOOR_W = 9'(BPM_MIN + BPM_STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       beat_q, beat_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       bpm_q, bpm_d;
  // bit0 = first synchronizer stage, bit1 = sync2, bit2 = sync3 (edge history)
  logic [2:0]       up_sync_q, dn_sync_q;

  logic             up_evt, dn_evt;
  logic [8:0]       bpm_up;
  logic [ACC_W-1:0] sum;

  assign up_evt = up_sync_q[1] & ~up_sync_q[2];
  assign dn_evt = dn_sync_q[1] & ~dn_sync_q[2];
  assign bpm_up = {1'b0, bpm_q} + 9'(BPM_STEP);
  assign sum    = acc_q + ACC_W'(bpm_q);

  // Tempo register: independent of the run state; simultaneous presses cancel.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bpm_d = bpm_q;
    if (up_evt && !dn_evt) begin
      bpm_d = (bpm_up > MAX_W) ? 8'(BPM_MAX) : bpm_up[7:0];
    end else if (dn_evt && !up_evt) begin
      bpm_d = ({1'b0, bpm_q} < DN_FLOOR_W) ? 8'(BPM_MIN) : bpm_q - 8'(BPM_STEP);
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    beat_d   = beat_q;
    strobe_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        acc_d  = '0;
        beat_d = '0;
        if (bus.sequencer_on) begin
          state_d  = RUN;
          strobe_d = 1'b1;   // announce step 0 on entry
        end
      end
      RUN: begin
        if (!bus.sequencer_on) begin
          // Stopping wins over a wrap in the same cycle.
          state_d = IDLE;
          acc_d   = '0;
          beat_d  = '0;
        end else if (sum >= THRESH_W) begin
          acc_d    = sum - THRESH_W;
          beat_d   = (beat_q == LAST_BEAT) ? 3'd0 : beat_q + 3'd1;
          strobe_d = 1'b1;
        end else begin
          acc_d = sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: async reset is applied to every flop here; none of this state is memory-like.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      beat_q    <= '0;
      strobe_q  <= 1'b0;
      bpm_q     <= 8'(BPM_DEFAULT);
      up_sync_q <= '0;
      dn_sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      acc_q     <= acc_d;
      beat_q    <= beat_d;
      strobe_q  <= strobe_d;
      bpm_q     <= bpm_d;
      up_sync_q <= {up_sync_q[1:0], bus.tempo_up};
      dn_sync_q <= {dn_sync_q[1:0], bus.tempo_down};
    end
  end

  assign bus.beat        = beat_q;
  assign bus.beat_strobe = strobe_q;
  assign bus.bpm         = bpm_q;

endmodule

// File: tb/tb_sequencer_beat_gen.sv
// Self-checking bench for sequencer_beat_gen at CLK_HZ=100 (THRESH=6000).
// Reference model counts total tempo units since run start; step count = units / THRESH.
module tb_sequencer_beat_gen;

  localparam int CLK_HZ      = 100;
  localparam int BPM_DEFAULT = 120;
  localparam int BPM_MIN     = 60;
  localparam int BPM_MAX     = 240;
  localparam int BPM_STEP    = 10;
  localparam int NUM_BEATS   = 8;
  localparam int THRESH      = CLK_HZ * 60;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  sequencer_beat_gen_if bus();

  sequencer_beat_gen #(
    .CLK_HZ(CLK_HZ), .BPM_DEFAULT(BPM_DEFAULT), .BPM_MIN(BPM_MIN),
    .BPM_MAX(BPM_MAX), .BPM_STEP(BPM_STEP), .NUM_BEATS(NUM_BEATS)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [2:0] up_hist, dn_hist;   // pin samples, bit0 = most recent
  int       m_bpm;
  bit       m_running;
  longint   m_units, m_steps;
  int       m_beat;
  bit       m_strobe;
  longint   cyc = 0;

  task automatic model_reset();
    up_hist   = '0;
    dn_hist   = '0;
    m_bpm     = BPM_DEFAULT;
    m_running = 1'b0;
    m_units   = 0;
    m_steps   = 0;
    m_beat    = 0;
    m_strobe  = 1'b0;
  endtask

  // Advance one clock, update the model, compare all outputs.
  task automatic tick();
    bit     up_evt, dn_evt;
    longint s;
    @(posedge clk);
    cyc++;
    // A press registers once the rising pin has been seen two samples ago.
    up_evt  = up_hist[1] && !up_hist[2];
    dn_evt  = dn_hist[1] && !dn_hist[2];
    up_hist = {up_hist[1:0], bit'(bus.tempo_up)};
    dn_hist = {dn_hist[1:0], bit'(bus.tempo_down)};
    if (!m_running) begin
      m_strobe = 1'b0;
      m_beat   = 0;
      if (bus.sequencer_on) begin
        m_running = 1'b1;
        m_units   = 0;
        m_steps   = 0;
        m_strobe  = 1'b1;
      end
    end else if (!bus.sequencer_on) begin
      m_running = 1'b0;
      m_strobe  = 1'b0;
      m_beat    = 0;
    end else begin
      m_units  += m_bpm;
      s         = m_units / THRESH;
      m_strobe  = (s != m_steps);
      m_steps   = s;
      m_beat    = int'(s % NUM_BEATS);
    end
    if (up_evt && !dn_evt)
      m_bpm = (m_bpm + BPM_STEP > BPM_MAX) ? BPM_MAX : m_bpm + BPM_STEP;
    else if (dn_evt && !up_evt)
      m_bpm = (m_bpm - BPM_STEP < BPM_MIN) ? BPM_MIN : m_bpm - BPM_STEP;
    #1;
    checks++;
    if ({bus.beat, bus.beat_strobe, bus.bpm} !== {3'(m_beat), m_strobe, 8'(m_bpm)}) begin
      errors++;
      $display("FAIL model_cycle %0d: got beat=%0d strobe=%0b bpm=%0d, expected beat=%0d strobe=%0b bpm=%0d",
               cyc, bus.beat, bus.beat_strobe, bus.bpm, m_beat, m_strobe, m_bpm);
    end
  endtask

  task automatic wait_strobe(input int max_cycles, output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (bus.beat_strobe !== 1'b1 && gap < max_cycles);
    checks++;
    if (bus.beat_strobe !== 1'b1) begin
      errors++;
      $display("FAIL strobe_timeout: no strobe within %0d cycles", max_cycles);
    end
  endtask

  task automatic press(input bit up, input int hold);
    if (up) bus.tempo_up = 1'b1; else bus.tempo_down = 1'b1;
    repeat (hold) tick();
    bus.tempo_up   = 1'b0;
    bus.tempo_down = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    model_reset();
    n_rst            = 1'b0;
    bus.sequencer_on = 1'b0;
    bus.tempo_up     = 1'b0;
    bus.tempo_down   = 1'b0;
    #12;
    checks++;
    if ({bus.beat, bus.beat_strobe, bus.bpm} !== {3'd0, 1'b0, 8'(BPM_DEFAULT)}) begin
      errors++;
      $display("FAIL reset_state: got beat=%0d strobe=%0b bpm=%0d, expected 0 0 %0d",
               bus.beat, bus.beat_strobe, bus.bpm, BPM_DEFAULT);
    end
    n_rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_steps_120();
    int gap, cnt;
    bus.sequencer_on = 1'b1;
    tick();
    checks++;
    if (bus.beat_strobe !== 1'b1 || bus.beat !== 3'd0) begin
      errors++;
      $display("FAIL run_entry: got strobe=%0b beat=%0d, expected 1 0", bus.beat_strobe, bus.beat);
    end
    for (int k = 1; k <= 16; k++) begin
      wait_strobe(60, gap);
      checks++;
      if (gap != 50 || bus.beat !== 3'(k % NUM_BEATS)) begin
        errors++;
        $display("FAIL step_120 #%0d: got gap=%0d beat=%0d, expected gap=50 beat=%0d",
                 k, gap, bus.beat, k % NUM_BEATS);
      end
    end
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.beat_strobe === 1'b1) cnt++;
    end
    checks++;
    if (cnt != 8) begin
      errors++;
      $display("FAIL strobes_per_400: got %0d, expected 8", cnt);
    end
  endtask

  task automatic test_stop_restart();
    int gap, n;
    n = 0;
    while (bus.beat !== 3'd5 && n < 10) begin
      wait_strobe(60, gap);
      n++;
    end
    repeat (10) tick();
    bus.sequencer_on = 1'b0;
    tick();
    checks++;
    if (bus.beat !== 3'd0 || bus.beat_strobe !== 1'b0) begin
      errors++;
      $display("FAIL stop: got beat=%0d strobe=%0b, expected 0 0", bus.beat, bus.beat_strobe);
    end
    bus.sequencer_on = 1'b1;
    tick();
    checks++;
    if (bus.beat !== 3'd0 || bus.beat_strobe !== 1'b1) begin
      errors++;
      $display("FAIL restart: got beat=%0d strobe=%0b, expected 0 1", bus.beat, bus.beat_strobe);
    end
    wait_strobe(60, gap);
    checks++;
    if (gap != 50 || bus.beat !== 3'd1) begin
      errors++;
      $display("FAIL restart_gap: got gap=%0d beat=%0d, expected 50 1", gap, bus.beat);
    end
    bus.sequencer_on = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_latency_and_both();
    bus.tempo_up   = 1'b1;
    bus.tempo_down = 1'b1;
    repeat (6) tick();
    checks++;
    if (bus.bpm !== 8'd120) begin
      errors++;
      $display("FAIL both_buttons: got bpm=%0d, expected 120", bus.bpm);
    end
    bus.tempo_up   = 1'b0;
    bus.tempo_down = 1'b0;
    repeat (4) tick();
    bus.tempo_up = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if (bus.bpm !== ((e < 3) ? 8'd120 : 8'd130)) begin
        errors++;
        $display("FAIL latency edge %0d: got bpm=%0d, expected %0d", e, bus.bpm, (e < 3) ? 120 : 130);
      end
    end
    repeat (5) tick();
    bus.tempo_up = 1'b0;
    repeat (4) tick();
    press(1'b0, 2);
    checks++;
    if (bus.bpm !== 8'd120) begin
      errors++;
      $display("FAIL down_once: got bpm=%0d, expected 120", bus.bpm);
    end
  endtask

  task automatic test_tempo_clamp();
    int exp_bpm;
    for (int i = 1; i <= 13; i++) begin
      press(1'b1, 2);
      exp_bpm = (120 + 10 * i > BPM_MAX) ? BPM_MAX : 120 + 10 * i;
      checks++;
      if (bus.bpm !== 8'(exp_bpm)) begin
        errors++;
        $display("FAIL up_press %0d: got bpm=%0d, expected %0d", i, bus.bpm, exp_bpm);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      press(1'b0, 2);
      exp_bpm = (240 - 10 * i < BPM_MIN) ? BPM_MIN : 240 - 10 * i;
      checks++;
      if (bus.bpm !== 8'(exp_bpm)) begin
        errors++;
        $display("FAIL down_press %0d: got bpm=%0d, expected %0d", i, bus.bpm, exp_bpm);
      end
    end
    press(1'b1, 100);
    checks++;
    if (bus.bpm !== 8'd70) begin
      errors++;
      $display("FAIL hold_up: got bpm=%0d, expected 70", bus.bpm);
    end
  endtask

  task automatic test_fractional_70();
    int gap, total, exp_gap;
    total = 0;
    bus.sequencer_on = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) begin
      wait_strobe(100, gap);
      total  += gap;
      exp_gap = (k * THRESH + 69) / 70 - ((k - 1) * THRESH + 69) / 70;
      checks++;
      if (gap != exp_gap || (gap != 85 && gap != 86)) begin
        errors++;
        $display("FAIL gap_70 #%0d: got %0d, expected %0d", k, gap, exp_gap);
      end
    end
    checks++;
    if (total != 600) begin
      errors++;
      $display("FAIL seven_steps_70: got %0d cycles, expected 600", total);
    end
    bus.sequencer_on = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    int gap, n;
    repeat (11) press(1'b1, 2);
    checks++;
    if (bus.bpm !== 8'd180) begin
      errors++;
      $display("FAIL bpm_180: got bpm=%0d, expected 180", bus.bpm);
    end
    bus.sequencer_on = 1'b1;
    tick();
    n = 0;
    while (bus.beat !== 3'd3 && n < 10) begin
      wait_strobe(40, gap);
      n++;
    end
    repeat (5) tick();
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if ({bus.beat, bus.beat_strobe, bus.bpm} !== {3'd0, 1'b0, 8'd120}) begin
      errors++;
      $display("FAIL async_reset: got beat=%0d strobe=%0b bpm=%0d, expected 0 0 120",
               bus.beat, bus.beat_strobe, bus.bpm);
    end
    model_reset();
    #1 n_rst = 1'b1;
    tick();
    wait_strobe(60, gap);
    checks++;
    if (gap != 50 || bus.beat !== 3'd1) begin
      errors++;
      $display("FAIL after_reset: got gap=%0d beat=%0d, expected 50 1", gap, bus.beat);
    end
    bus.sequencer_on = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    bus.sequencer_on = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) bus.sequencer_on = ~bus.sequencer_on;
      if ($urandom_range(0, 29) == 0)  bus.tempo_up     = ~bus.tempo_up;
      if ($urandom_range(0, 29) == 0)  bus.tempo_down   = ~bus.tempo_down;
      tick();
    end
    bus.sequencer_on = 1'b0;
    bus.tempo_up     = 1'b0;
    bus.tempo_down   = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_steps_120();
    test_stop_restart();
    test_latency_and_both();
    test_tempo_clamp();
    test_fractional_70();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
